// File: rtl/amstrad_pkg.sv
// Shared constants for the Amstrad boot path: ROM page bases, page count and
// the boot loader FSM state encoding.
package amstrad_pkg;

  localparam int PAGE_COUNT = 8;

  // SDRAM 16 KB page bases for ROM pages 0..3 (MF2 at the top); 4..7 reuse them in bank 1
  localparam logic [8:0] PAGE_BASE_0 = 9'h000;
  localparam logic [8:0] PAGE_BASE_1 = 9'h100;
  localparam logic [8:0] PAGE_BASE_2 = 9'h107;
  localparam logic [8:0] PAGE_BASE_3 = 9'h1FF;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_WAIT_SLOT = 2'd1;
  localparam state_t ST_WRITE     = 2'd2;
  localparam state_t ST_DONE      = 2'd3;

endpackage

// File: rtl/boot_page_map.sv
// Maps a download page index to its SDRAM page base and bank; pages past
// PAGE_COUNT are flagged invalid so the caller can drop them.
module boot_page_map
  import amstrad_pkg::*;
(
  input  logic [10:0] p,
  output logic [8:0]  base,
  output logic [1:0]  bank,
  output logic        valid
);

  always_comb begin
    valid = (p < 11'(PAGE_COUNT));
    bank  = {1'b0, p[2]};
    case (p[1:0])
      2'd0:    base = PAGE_BASE_0;
      2'd1:    base = PAGE_BASE_1;
      2'd2:    base = PAGE_BASE_2;
      default: base = PAGE_BASE_3;
    endcase
  end

endmodule

// File: rtl/boot_loader_ctl.sv
// Streams the HPS ROM download into SDRAM one byte per reference slot,
// stalling the stream while a byte waits for and occupies its slot.
module boot_loader_ctl
  import amstrad_pkg::*;
#(
  parameter int SLOT_WAIT_MAX = 31
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_ref,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        dl_wait,
  output logic        mem_we,
  output logic [22:0] mem_addr,
  output logic [1:0]  mem_bank,
  output logic [7:0]  mem_din,
  output logic        busy,
  output logic        done,
  output logic [7:0]  page_seen,
  output logic        overrun_err
);

  localparam int CNT_W = $clog2(SLOT_WAIT_MAX + 1);

  state_t             state;
  logic               act_prev;
  logic               done_pend;
  logic [CNT_W-1:0]   wait_cnt;
  logic [2:0]         page_l;
  logic [8:0]         map_base;
  logic [1:0]         map_bank;
  logic               map_valid;
  logic               rise;
  logic               fall;
  logic               accept;

  boot_page_map u_page_map (
    .p     (dl_addr[24:14]),
    .base  (map_base),
    .bank  (map_bank),
    .valid (map_valid)
  );

  assign rise   = dl_active & ~act_prev;
  assign fall   = ~dl_active & act_prev;
  // A byte arriving on the falling-edge cycle still belongs to the download
  assign accept = dl_wr & (dl_active | act_prev) & map_valid & (state == ST_IDLE);
  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= ST_IDLE;
      act_prev    <= 1'b0;
      done_pend   <= 1'b0;
      wait_cnt    <= '0;
      page_l      <= '0;
      dl_wait     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_bank    <= '0;
      mem_din     <= '0;
      page_seen   <= '0;
      overrun_err <= 1'b0;
    end else begin
      act_prev <= dl_active;
      if (rise) begin
        page_seen   <= '0;
        overrun_err <= 1'b0;
      end
      if (dl_wr && state != ST_IDLE) overrun_err <= 1'b1;
      if (fall && (state != ST_IDLE || accept)) done_pend <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_WAIT_SLOT;
            dl_wait  <= 1'b1;
            mem_addr <= {map_base, dl_addr[13:0]};
            mem_bank <= map_bank;
            mem_din  <= dl_data;
            page_l   <= dl_addr[16:14];
            wait_cnt <= '0;
          end else if (fall || done_pend) begin
            state     <= ST_DONE;
            done_pend <= 1'b0;
          end
        end
        ST_WAIT_SLOT: begin
          if (ce_ref) begin
            mem_we <= 1'b1;
            state  <= ST_WRITE;
          end else if (wait_cnt == CNT_W'(SLOT_WAIT_MAX - 1)) begin
            overrun_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_WRITE: begin
          // The write occupies one full refresh slot period
          if (ce_ref) begin
            mem_we            <= 1'b0;
            dl_wait           <= 1'b0;
            page_seen[page_l] <= 1'b1;
            state             <= ST_IDLE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/boot_loader_ctl.md
BOOT_LOADER_CTL -- requirements
Module: boot_loader_ctl

Interface
REQ-001 SHALL have parameter SLOT_WAIT_MAX, default 31, the maximum number of clk_sys cycles waited for a ce_ref slot before overrun_err is set.
REQ-002 SHALL have port clk_sys, input, 1, system clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high.
REQ-004 SHALL have port ce_ref, input, 1, SDRAM reference slot strobe (1 cycle in 16).
REQ-005 SHALL have port dl_active, input, 1, ROM download in progress (ioctl index 0).
REQ-006 SHALL have port dl_wr, input, 1, byte-valid strobe from the HPS download stream.
REQ-007 SHALL have port dl_addr, input, 25, byte offset within the download image.
REQ-008 SHALL have port dl_data, input, 8, download byte.
REQ-009 SHALL have port dl_wait, output, 1, stall request to the HPS stream.
REQ-010 SHALL have ports mem_we (1), mem_addr (23), mem_bank (2) and mem_din (8), all outputs forming the SDRAM write request.
REQ-011 SHALL have port busy, output, 1, high while the FSM is not IDLE.
REQ-012 SHALL have port done, output, 1, a one-cycle pulse marking download completion.
REQ-013 SHALL have port page_seen, output, 8, a bitmap of the 16 KB pages written.
REQ-014 SHALL have port overrun_err, output, 1, sticky error flag.

Function
REQ-015 SHALL decode page p = dl_addr[24:14] and map it as follows: p 0/4 to 9'h000, p 1/5 to 9'h100, p 2/6 to 9'h107, p 3/7 to 9'h1FF (MF2); banks 0 for p 0-3 and 1 for p 4-7; mem_addr[13:0] = dl_addr[13:0].
REQ-016 SHALL drop bytes with p > 7 without asserting dl_wait or mem_we.
REQ-017 SHALL implement states IDLE, WAIT_SLOT, WRITE and DONE.
REQ-018 SHALL, in IDLE, on dl_active & dl_wr with p <= 7, latch the address, bank and data, set dl_wait=1 on the next cycle and move to WAIT_SLOT.
REQ-019 SHALL, in WAIT_SLOT, on ce_ref assert mem_we=1 and move to WRITE.
REQ-020 SHALL, in WRITE, on the next ce_ref deassert mem_we and dl_wait in the same cycle, set page_seen[p], and return to IDLE.
REQ-021 SHALL produce a write-to-release latency of exactly one ce_ref period with mem_we high for exactly 16 cycles when ce_ref is regular.
REQ-022 SHALL hold mem_addr, mem_bank and mem_din stable from WAIT_SLOT entry through WRITE exit.
REQ-023 SHALL set overrun_err, ignore the byte, and leave the FSM unaffected when dl_wr arrives while not IDLE.
REQ-024 SHALL set overrun_err when WAIT_SLOT lasts SLOT_WAIT_MAX cycles without ce_ref, remaining in WAIT_SLOT.
REQ-025 SHALL clear page_seen and overrun_err on a dl_active rising edge.
REQ-026 SHALL, on a dl_active falling edge in IDLE, enter DONE, pulse done for one cycle, and return to IDLE.
REQ-027 SHALL, on a dl_active falling edge while WAIT_SLOT or WRITE, complete the pending write, then enter DONE.
REQ-028 SHALL, when a dl_active falling edge and dl_wr coincide, accept the byte first and emit done after its write.
REQ-029 SHALL not exceed one done pulse per dl_active low period.

Reset
REQ-030 SHALL, on reset, force IDLE, with dl_wait, mem_we, busy and done at 0, mem_addr, mem_bank and mem_din at 0, and page_seen and overrun_err at 0.
REQ-031 SHALL, on reset asserted mid-write, abort the write: mem_we drops the next cycle, no page_seen bit is set, and no done is emitted.
REQ-032 SHALL sample the dl_active edge detector's previous value as 0 after reset, so that dl_active already high counts as a rising edge.

Structure
REQ-033 SHALL take the page base constants (9'h000/9'h100/9'h107/9'h1FF), the FSM state enum, and the page count of 8 from shared package amstrad_pkg.
REQ-034 SHALL place page decoding in one combinational sub-module, boot_page_map (input p[10:0]; outputs base[8:0], bank[1:0], valid).

Verification
REQ-035 SHALL cover: dl_addr=0x04123 with data 0xA5 -> mem_addr=0x400123 (9'h100 page), bank 0, mem_din=0xA5, mem_we high for 16 cycles, page_seen=0x02.
REQ-036 SHALL cover: dl_addr=0x1C000 with data 0x3C -> mem_addr=0x7FC000, bank 1, page_seen[7]=1.
REQ-037 SHALL cover: dl_addr=0x20000 -> no dl_wait, no mem_we, page_seen unchanged.
REQ-038 SHALL cover: a second dl_wr two cycles after the first -> overrun_err=1 and exactly one mem_we pulse.
REQ-039 SHALL cover: dl_active falling during WRITE -> done pulses 1 cycle after mem_we falls; falling in IDLE -> done 1 cycle later.
REQ-040 SHALL cover: reset asserted in WRITE -> mem_we=0 the next cycle, page_seen=0, done never pulses.
